// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scan-code decoder: strips E0/F0 prefixes and turns final bytes into
// make/break events, tracking the held key, shift/caps state, press count and ASCII.
module ps2_scan_decoder (
  input  logic       clk,
  input  logic       clrn,
  input  logic       code_valid,
  input  logic [7:0] code,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_held,
  output logic [7:0] ascii,
  output logic       make_pulse,
  output logic       break_pulse,
  output logic [7:0] press_count,
  output logic       shift,
  output logic       caps
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXT = 2'd1, BRK = 2'd2, EXT_BRK = 2'd3} state_e;

  state_e     state_q, state_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_ext_q, key_ext_d;
  logic       key_held_q, key_held_d;
  logic [8:0] held_key_q, held_key_d;
  logic       make_q, make_d;
  logic       break_q, break_d;
  logic [7:0] press_count_q, press_count_d;
  logic       lshift_q, lshift_d;
  logic       rshift_q, rshift_d;
  logic       caps_q, caps_d;
  logic       caps_down_q, caps_down_d;
  logic [7:0] ascii_q, ascii_d;

  logic       final_s;
  logic       ext_s;
  logic       brk_s;
  logic [8:0] key_s;
  logic       held_match_s;

  // Extended keys have no ASCII; letters follow shift^caps, digits ignore shift.
  function automatic logic [7:0] ascii_of(input logic [8:0] key, input logic held,
                                          input logic upper);
    logic [7:0] base;
    logic [7:0] a;
    base = upper ? 8'h41 : 8'h61;
    if (!held || key[8]) begin
      a = 8'h00;
    end else begin
      case (key[7:0])
        8'h1C: a = base + 8'd0;   8'h32: a = base + 8'd1;   8'h21: a = base + 8'd2;
        8'h23: a = base + 8'd3;   8'h24: a = base + 8'd4;   8'h2B: a = base + 8'd5;
        8'h34: a = base + 8'd6;   8'h33: a = base + 8'd7;   8'h43: a = base + 8'd8;
        8'h3B: a = base + 8'd9;   8'h42: a = base + 8'd10;  8'h4B: a = base + 8'd11;
        8'h3A: a = base + 8'd12;  8'h31: a = base + 8'd13;  8'h44: a = base + 8'd14;
        8'h4D: a = base + 8'd15;  8'h15: a = base + 8'd16;  8'h2D: a = base + 8'd17;
        8'h1B: a = base + 8'd18;  8'h2C: a = base + 8'd19;  8'h3C: a = base + 8'd20;
        8'h2A: a = base + 8'd21;  8'h1D: a = base + 8'd22;  8'h22: a = base + 8'd23;
        8'h35: a = base + 8'd24;  8'h1A: a = base + 8'd25;
        8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
        8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
        8'h3E: a = 8'h38;  8'h46: a = 8'h39;
        8'h29: a = 8'h20;
        8'h5A: a = 8'h0D;
        default: a = 8'h00;
      endcase
    end
    return a;
  endfunction

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q       <= IDLE;
      key_code_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      key_held_q    <= 1'b0;
      held_key_q    <= 9'h000;
      make_q        <= 1'b0;
      break_q       <= 1'b0;
      press_count_q <= 8'h00;
      lshift_q      <= 1'b0;
      rshift_q      <= 1'b0;
      caps_q        <= 1'b0;
      caps_down_q   <= 1'b0;
      ascii_q       <= 8'h00;
    end else begin
      state_q       <= state_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      key_held_q    <= key_held_d;
      held_key_q    <= held_key_d;
      make_q        <= make_d;
      break_q       <= break_d;
      press_count_q <= press_count_d;
      lshift_q      <= lshift_d;
      rshift_q      <= rshift_d;
      caps_q        <= caps_d;
      caps_down_q   <= caps_down_d;
      ascii_q       <= ascii_d;
    end
  end

  // E0 restarts a sequence from any state, dropping a pending F0.
  always_comb begin
    state_d = state_q;
    if (code_valid) begin
      if (code == 8'hE0) begin
        state_d = EXT;
      end else if (code == 8'hF0) begin
        case (state_q)
          IDLE:    state_d = BRK;
          EXT:     state_d = EXT_BRK;
          default: state_d = state_q;
        endcase
      end else begin
        state_d = IDLE;
      end
    end else begin
      state_d = state_q;
    end
  end

  always_comb begin
    ext_s        = (state_q == EXT) || (state_q == EXT_BRK);
    brk_s        = (state_q == BRK) || (state_q == EXT_BRK);
    key_s        = {ext_s, code};
    held_match_s = key_held_q && (held_key_q == key_s);
    final_s      = code_valid && (code != 8'hE0) && (code != 8'hF0) &&
                   (code != 8'h00) && (code != 8'hFF) && (code != 8'hAA);

    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    key_held_d    = key_held_q;
    held_key_d    = held_key_q;
    make_d        = 1'b0;
    break_d       = 1'b0;
    press_count_d = press_count_q;
    lshift_d      = lshift_q;
    rshift_d      = rshift_q;
    caps_d        = caps_q;
    caps_down_d   = caps_down_q;
    ascii_d       = ascii_of(held_key_q, key_held_q, (lshift_q | rshift_q) ^ caps_q);

    if (final_s) begin
      key_code_d = code;
      key_ext_d  = ext_s;
      if (!brk_s) begin
        make_d = 1'b1;
        case (key_s)
          9'h012: lshift_d = 1'b1;
          9'h059: rshift_d = 1'b1;
          9'h058: begin
            caps_d      = caps_down_q ? caps_q : ~caps_q;
            caps_down_d = 1'b1;
          end
          default: begin
            if (!held_match_s) begin
              held_key_d    = key_s;
              key_held_d    = 1'b1;
              press_count_d = press_count_q + 8'd1;
            end else begin
              held_key_d    = held_key_q;
            end
          end
        endcase
      end else begin
        break_d = 1'b1;
        case (key_s)
          9'h012:  lshift_d    = 1'b0;
          9'h059:  rshift_d    = 1'b0;
          9'h058:  caps_down_d = 1'b0;
          default: caps_down_d = caps_down_q;
        endcase
        key_held_d = held_match_s ? 1'b0 : key_held_q;
      end
    end else begin
      make_d = 1'b0;
    end
  end

  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_held    = key_held_q;
  assign ascii       = ascii_q;
  assign make_pulse  = make_q;
  assign break_pulse = break_q;
  assign press_count = press_count_q;
  assign shift       = lshift_q | rshift_q;
  assign caps        = caps_q;

endmodule
